// File: rtl/vga_sync_monitor.sv
// VGA sync monitor: measures line/frame timing from raw syncs, tracks lock and recovers x/y.
// Build macro VGA_MON_EXPECT_EN additionally pins lock to EXP_H_TOTAL / EXP_V_TOTAL.
module vga_sync_monitor #(
    parameter int unsigned CNT_W       = 10,
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned EXP_H_TOTAL = 800,
    parameter int unsigned EXP_V_TOTAL = 525
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pix_en,
    input  logic             h_sync,
    input  logic             v_sync,
    input  logic             n_blank,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             pix_valid,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] v_total,
    output logic             locked,
    output logic             timing_err,
    output logic             frame_start
);

    localparam int unsigned        MATCH_W = 4;
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   EXP_H   = CNT_W'(EXP_H_TOTAL);
    localparam logic [CNT_W-1:0]   EXP_V   = CNT_W'(EXP_V_TOTAL);
    localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_FRAMES);
`ifdef VGA_MON_EXPECT_EN
    localparam logic EXP_EN = 1'b1;
`else
    localparam logic EXP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               h_prev_q, h_prev_d;
    logic               v_prev_q, v_prev_d;
    logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
    logic [CNT_W-1:0]   h_total_q, h_total_d;
    logic [CNT_W-1:0]   v_total_q, v_total_d;
    logic               line_ok_q, line_ok_d;
    logic [CNT_W-1:0]   x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0]   y_cnt_q, y_cnt_d;
    logic               line_active_q, line_active_d;
    logic [CNT_W-1:0]   x_q, x_d;
    logic [CNT_W-1:0]   y_q, y_d;
    logic               pix_valid_q, pix_valid_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]   ref_h_q, ref_h_d;
    logic [CNT_W-1:0]   ref_v_q, ref_v_d;
    logic               locked_q, locked_d;
    logic               timing_err_q, timing_err_d;
    logic               frame_start_q, frame_start_d;

    logic               hfall, vfall;
    logic [CNT_W-1:0]   h_tot_new, v_tot_new;
    logic               line_ok_new, exp_ok, frame_match;
    logic               h_bad, v_bad, sat_err;
    logic [MATCH_W-1:0] match_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Next-state: line update first, then frame update, then lock decision on the combined view.
    always_comb begin
        hfall       = pix_en & h_prev_q & ~h_sync;
        vfall       = pix_en & v_prev_q & ~v_sync;
        h_tot_new   = hfall ? h_cnt_q : h_total_q;
        v_tot_new   = hfall ? sat_inc(v_cnt_q) : v_cnt_q;
        line_ok_new = line_ok_q & ~(hfall & (h_cnt_q != h_total_q));
        exp_ok      = ~EXP_EN | ((h_tot_new == EXP_H) & (v_tot_new == EXP_V));
        frame_match = line_ok_new & (h_tot_new == ref_h_q) & (v_tot_new == ref_v_q)
                    & (h_tot_new != '0) & (v_tot_new != '0) & exp_ok;
        h_bad       = hfall & ((h_cnt_q != ref_h_q) | (EXP_EN & (h_cnt_q != EXP_H)));
        v_bad       = vfall & ((v_tot_new != ref_v_q) | (EXP_EN & (v_tot_new != EXP_V)));
        match_inc   = match_cnt_q + MATCH_W'(1);
        sat_err     = 1'b0;

        state_d       = state_q;
        h_prev_d      = h_prev_q;
        v_prev_d      = v_prev_q;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        line_ok_d     = line_ok_q;
        x_cnt_d       = x_cnt_q;
        y_cnt_d       = y_cnt_q;
        line_active_d = line_active_q;
        x_d           = x_q;
        y_d           = y_q;
        pix_valid_d   = pix_valid_q;
        match_cnt_d   = match_cnt_q;
        ref_h_d       = ref_h_q;
        ref_v_d       = ref_v_q;
        timing_err_d  = 1'b0;
        frame_start_d = 1'b0;

        if (pix_en) begin
            h_prev_d = h_sync;
            v_prev_d = v_sync;

            h_cnt_d   = hfall ? CNT_W'(1) : sat_inc(h_cnt_q);
            h_total_d = h_tot_new;
            line_ok_d = line_ok_new;
            v_cnt_d   = v_tot_new;
            if (vfall) begin
                v_total_d     = v_tot_new;
                v_cnt_d       = '0;
                line_ok_d     = 1'b1;
                frame_start_d = 1'b1;
            end

            if (n_blank) begin
                x_d           = x_cnt_q;
                y_d           = y_cnt_q;
                pix_valid_d   = locked_q;
                x_cnt_d       = sat_inc(x_cnt_q);
                line_active_d = 1'b1;
            end else begin
                x_d         = CNT_MAX;
                y_d         = CNT_MAX;
                pix_valid_d = 1'b0;
            end
            if (hfall) begin
                x_cnt_d       = '0;
                line_active_d = 1'b0;
                if (line_active_q) begin
                    y_cnt_d = sat_inc(y_cnt_q);
                end
            end
            if (vfall) begin
                y_cnt_d = '0;
            end

            // A stuck h_sync shows up as the line counter pinning at its maximum.
            sat_err = (h_cnt_d == CNT_MAX);

            unique case (state_q)
                SEARCH: begin
                    if (vfall) begin
                        state_d     = CHECK;
                        match_cnt_d = '0;
                        ref_h_d     = '0;
                        ref_v_d     = '0;
                    end
                end
                CHECK: begin
                    if (sat_err) begin
                        state_d = SEARCH;
                    end else if (vfall) begin
                        if (frame_match) begin
                            match_cnt_d = match_inc;
                            if (match_inc == LOCK_N) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            match_cnt_d = '0;
                            ref_h_d     = h_tot_new;
                            ref_v_d     = v_tot_new;
                        end
                    end
                end
                LOCKED: begin
                    if (sat_err || h_bad || v_bad) begin
                        timing_err_d = 1'b1;
                        state_d      = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= SEARCH;
            h_prev_q      <= 1'b1;
            v_prev_q      <= 1'b1;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            line_ok_q     <= 1'b0;
            x_cnt_q       <= '0;
            y_cnt_q       <= '0;
            line_active_q <= 1'b0;
            x_q           <= CNT_MAX;
            y_q           <= CNT_MAX;
            pix_valid_q   <= 1'b0;
            match_cnt_q   <= '0;
            ref_h_q       <= '0;
            ref_v_q       <= '0;
            locked_q      <= 1'b0;
            timing_err_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_prev_q      <= h_prev_d;
            v_prev_q      <= v_prev_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            line_ok_q     <= line_ok_d;
            x_cnt_q       <= x_cnt_d;
            y_cnt_q       <= y_cnt_d;
            line_active_q <= line_active_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_valid_q   <= pix_valid_d;
            match_cnt_q   <= match_cnt_d;
            ref_h_q       <= ref_h_d;
            ref_v_q       <= ref_v_d;
            locked_q      <= locked_d;
            timing_err_q  <= timing_err_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign pix_valid   = pix_valid_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign timing_err  = timing_err_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a scaled-down raster (20 strobes x 12 lines).
module tb_vga_sync_monitor;

    localparam int CNT_W  = 10;
    localparam int H_TOT  = 20;
    localparam int V_TOT  = 12;
    localparam int H_VIS0 = 8;
    localparam int V_VIS0 = 4;
    localparam logic [CNT_W-1:0] ONES = '1;
`ifdef VGA_MON_EXPECT_EN
    localparam logic CAN19 = 1'b0;
`else
    localparam logic CAN19 = 1'b1;
`endif

    logic clk     = 1'b0;
    logic n_rst   = 1'b0;
    logic pix_en  = 1'b0;
    logic h_sync  = 1'b1;
    logic v_sync  = 1'b1;
    logic n_blank = 1'b0;
    logic [CNT_W-1:0] x, y, h_total, v_total;
    logic pix_valid, locked, timing_err, frame_start;

    typedef struct packed {
        logic [CNT_W-1:0] x;
        logic [CNT_W-1:0] y;
        logic             v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   err_hi = 0;
    int   fs_hi  = 0;
    int   err_base = 0;
    int   vf_cnt = 0;
    int   y_base = V_VIS0;
    int   h_len  = H_TOT;
    logic exp_lock  = 1'b0;
    logic can_lock  = 1'b1;
    logic err_armed = 1'b0;
    logic strb_seen = 1'b0;

    vga_sync_monitor #(
        .CNT_W      (CNT_W),
        .LOCK_FRAMES(2),
        .EXP_H_TOTAL(H_TOT),
        .EXP_V_TOTAL(V_TOT)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .pix_en     (pix_en),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .n_blank    (n_blank),
        .x          (x),
        .y          (y),
        .pix_valid  (pix_valid),
        .h_total    (h_total),
        .v_total    (v_total),
        .locked     (locked),
        .timing_err (timing_err),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) strb_seen <= pix_en;

    // Monitor: pulse counters plus one scoreboard pop per strobe the DUT consumed.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (timing_err) err_hi++;
        if (frame_start) fs_hi++;
        if (strb_seen && n_rst) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL pixel_sb_empty: got output x=%0d y=%0d with no expectation queued", x, y);
            end else begin
                e = sb.pop_front();
                if ({x, y, pix_valid} !== e) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d v=%0b, expected x=%0d y=%0d v=%0b",
                             x, y, pix_valid, e.x, e.y, e.v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, x, ONES);
        chk({tag, "_y"}, y, ONES);
        chk({tag, "_pix_valid"}, pix_valid, 0);
        chk({tag, "_h_total"}, h_total, 0);
        chk({tag, "_v_total"}, v_total, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_timing_err"}, timing_err, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
    endtask

    task automatic strobe(input logic hs, input logic vs, input logic nb, input exp_t e);
        @(posedge clk); #1;
        pix_en = 1'b1; h_sync = hs; v_sync = vs; n_blank = nb;
        sb.push_back(e);
        @(posedge clk); #1;
        pix_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_line(input int l, input int len);
        logic hs, vs, nb;
        exp_t e;
        int   fs0;
        for (int s = 0; s < len; s++) begin
            hs  = !(s >= 2 && s <= 4);
            vs  = !(l == 1 || l == 2);
            nb  = (s >= H_VIS0) && (s < H_TOT) && (l >= V_VIS0);
            e.x = nb ? CNT_W'(s - H_VIS0) : ONES;
            e.y = nb ? CNT_W'(l - y_base) : ONES;
            e.v = nb & exp_lock;
            fs0 = fs_hi;
            strobe(hs, vs, nb, e);
            if (l == 1 && s == 0) begin
                vf_cnt++;
                y_base = V_VIS0;
                if (vf_cnt == 4 && can_lock) exp_lock = 1'b1;
                chk("frame_start_pulse", fs_hi - fs0, 1);
                chk("locked_after_vfall", locked, exp_lock);
            end
            if (s == 2 && err_armed) begin
                err_armed = 1'b0;
                exp_lock  = 1'b0;
                vf_cnt    = 0;
                chk("err_pulse_width", err_hi - err_base, 1);
                chk("locked_drop", locked, 0);
            end
        end
    endtask

    task automatic send_frame(input int long_line);
        for (int l = 0; l < V_TOT; l++) begin
            send_line(l, (l == long_line) ? h_len + 1 : h_len);
            if (l == long_line) begin
                err_armed = 1'b1;
                err_base  = err_hi;
            end
        end
    endtask

    task automatic restart(input logic allow_lock);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        exp_lock = 1'b0;
        vf_cnt   = 0;
        y_base   = V_VIS0;
        can_lock = allow_lock;
    endtask

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    initial begin : stim
        exp_t eb;
        int   k;
        eb.x = ONES; eb.y = ONES; eb.v = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        restart(1'b1);

        // Clean frames: lock after the 4th vfall.
        for (int f = 0; f < 5; f++) send_frame(-1);
        chk("std_h_total", h_total, H_TOT);
        chk("std_v_total", v_total, V_TOT);
        chk("std_locked", locked, 1);

        // One long line while locked, then relock.
        send_frame(6);
        for (int f = 0; f < 4; f++) send_frame(-1);
        chk("relock_after_long_line", locked, 1);

        // h_sync stuck high: error when line counter saturates.
        err_base = err_hi;
        k = 0;
        while (err_hi == err_base && k < 1100) begin
            k++;
            strobe(1'b1, 1'b1, 1'b0, eb);
        end
        chk("sat_strobe_count", k, 1005);
        chk("sat_locked", locked, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b1, 1'b0, eb);
        chk("sat_err_width", err_hi - err_base, 1);
        chk("sat_still_unlocked", locked, 0);
        exp_lock = 1'b0;
        vf_cnt   = 0;
        for (int f = 0; f < 4; f++) send_frame(-1);
        chk("relock_after_sat", locked, 1);

        // Asynchronous reset in the middle of a visible frame.
        for (int l = 0; l < 6; l++) send_line(l, h_len);
        #2 n_rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        exp_lock = 1'b0;
        vf_cnt   = 0;
        y_base   = 6;
        for (int l = 6; l < V_TOT; l++) send_line(l, h_len);
        for (int f = 0; f < 4; f++) send_frame(-1);
        chk("relock_after_midrst", locked, 1);

        // One-strobe-short lines.
        restart(CAN19);
        h_len = H_TOT - 1;
        for (int f = 0; f < 5; f++) send_frame(-1);
        chk("short_line_locked", locked, CAN19);
`ifndef VGA_MON_EXPECT_EN
        chk("short_line_h_total", h_total, H_TOT - 1);
        chk("short_line_v_total", v_total, V_TOT);
`endif

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side companion to the VGA timing generator. Samples h_sync, v_sync and n_blank once per pixel strobe.
- Measures line length and frame height, and declares lock after a run of consistent frames.
- Recovers the visible-area pixel coordinates.
- Used in loopback and self-check builds to confirm the generated VGA timing, and by downstream capture logic that needs x/y from raw sync signals.

Parameters:
- CNT_W, 10, width of the pixel, line, x and y counters; all counters saturate at 2^CNT_W-1.
- LOCK_FRAMES, 2, number of consecutive matching frames required to assert locked (range 1..15).
- EXP_H_TOTAL, 800, expected pixel strobes per line; used only with VGA_MON_EXPECT_EN.
- EXP_V_TOTAL, 525, expected lines per frame; used only with VGA_MON_EXPECT_EN.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- pix_en  in  1  single-cycle pixel strobe; all other inputs are sampled only when it is 1
- h_sync  in  1  horizontal sync, active low
- v_sync  in  1  vertical sync, active low
- n_blank  in  1  1 = visible pixel
- x  out  CNT_W  recovered column; all ones when not valid
- y  out  CNT_W  recovered row; all ones when not valid
- pix_valid  out  1  x/y describe a visible pixel while locked
- h_total  out  CNT_W  last measured line length, in strobes
- v_total  out  CNT_W  last measured frame height, in lines
- locked  out  1  timing is stable
- timing_err  out  1  one-cycle pulse when lock is lost
- frame_start  out  1  one-cycle pulse on each detected v_sync falling edge

Behaviour:
- Reset (async, n_rst=0): all counters and registers go to 0; x and y go to all ones; pix_valid, locked, timing_err, frame_start go to 0; state = SEARCH. Previous-sample registers for h_sync and v_sync reset to 1.
- Between strobes, all state holds, except that timing_err and frame_start drop to 0 one cycle after pulsing.
- Edge detect, on a strobe:
  - hfall = (previous sampled h_sync = 1) and (current h_sync = 0).
  - vfall is defined the same way on v_sync.
  - The previous-sample registers update only on strobes.
- Line measurement:
  - h_cnt increments on every strobe.
  - On hfall: h_total <= h_cnt, then h_cnt <= 1 (the current strobe counts as strobe 1).
  - line_ok is cleared if the new h_total differs from the previous h_total.
- Frame measurement:
  - v_cnt increments on each hfall.
  - On vfall: v_total <= v_cnt, including any hfall on the same strobe; then v_cnt <= 0 and line_ok <= 1.
  - frame_start pulses for 1 clk, registered, on the cycle after the vfall strobe.
- Coordinates:
  - On a strobe with n_blank=1: x <= x_cnt, y <= y_cnt, pix_valid <= locked (updated next cycle); then x_cnt++ and line_active <= 1.
  - On a strobe with n_blank=0: x and y <= all ones, pix_valid <= 0.
  - On hfall: x_cnt <= 0; if line_active then y_cnt++; line_active <= 0.
  - On vfall: y_cnt <= 0.
  - Latency: input strobe to registered x/y output is 1 clk.
- Lock FSM, evaluated on vfall strobes unless stated otherwise:
  - SEARCH: first vfall -> CHECK with match_cnt=0 and stored reference = 0.
  - CHECK:
    - A frame matches if line_ok=1, h_total equals the stored h reference, v_total equals the stored v reference, and neither is 0.
    - Match: match_cnt++. Mismatch: match_cnt <= 0 and the references are reloaded.
    - When match_cnt reaches LOCK_FRAMES -> LOCKED; locked=1 from the next cycle.
  - LOCKED:
    - Any hfall whose line length differs from the reference, or any vfall whose v_total differs from the reference, causes: timing_err pulse (1 clk), locked=0, state -> SEARCH.
- Loss of sync: if h_cnt reaches saturation, that is the error. In CHECK the FSM -> SEARCH with no pulse; in LOCKED it -> SEARCH with timing_err.
- Simultaneous events: if hfall and vfall fall on one strobe, the line update is applied before the frame update. A mismatch on that strobe takes priority over a match.
- pix_en held high every cycle is legal; pix_en=0 forever holds all state.

Optional Feature:
- VGA_MON_EXPECT_EN defined: the CHECK match condition additionally requires h_total==EXP_H_TOTAL and v_total==EXP_V_TOTAL. In LOCKED, any deviation from those values fires timing_err.
- VGA_MON_EXPECT_EN undefined: EXP_* are ignored; any self-consistent timing locks.

Test Plan:
- Standard stimulus: 640x480 timing, 800 strobes/line, 525 lines, pix_en every 3rd clk, hsync low on strobes 17-112, vsync low on lines 11-12. Required response: h_total=800, v_total=525, locked rises the cycle after the 4th vfall with LOCK_FRAMES=2.
- First visible pixel of a frame -> x=0, y=0, pix_valid=1. Last visible pixel -> x=639, y=479. Blanked strobes -> x=y=10'h3FF, pix_valid=0.
- While locked, lengthen one line to 801 strobes -> timing_err high for exactly 1 clk; locked=0 on the following cycle; relock after 4 further clean vfalls.
- Stop h_sync toggling (held 1) while locked -> timing_err when h_cnt hits 1023; state SEARCH; locked stays 0.
- Assert n_rst mid-frame while locked -> all outputs at reset values immediately; relock after 4 vfalls.
- With VGA_MON_EXPECT_EN defined and a stable 799-strobe line -> locked never asserts. Without the macro -> locks with h_total=799.
